// File: rtl/core_fetch_pkg.sv
// Shared types for the fetch sequencer: FSM state encoding and the buffered fetch entry.
// Optional perf counters in the top are enabled with CORE_FETCH_PERF_EN.
package core_fetch_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned ILEN     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    // Layout matches the {pc, instr} word stored in the fetch buffer.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN-1:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/core_fetch_fifo.sv
// Small synchronous FIFO with flush; the head is read straight from the storage flops,
// so head/head_valid are registered and hold still while nothing is popped.
module core_fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign head_valid = (count != '0);
    assign head       = mem[rd_ptr];
    assign do_pop     = pop && head_valid;
    // A full FIFO can still take a write in the cycle its head leaves.
    assign do_push    = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/core_fetch_ctrl.sv
// Fetch sequencer: one-outstanding req/gnt/rvalid fetches, redirect hold/replay, stale
// response kill, and a {pc,instr} buffer toward ID. CORE_FETCH_PERF_EN adds perf counters.
module core_fetch_ctrl
    import core_fetch_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] pc_curr_i,
    output logic            pc_write_o,
    output logic            branch_taken_o,
    output logic [XLEN-1:0] pc_branch_o,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] pc_branch_i,
    output logic            instr_req_o,
    output logic [XLEN-1:0] instr_addr_o,
    input  logic            instr_gnt_i,
    input  logic            instr_rvalid_i,
    input  logic [31:0]     instr_rdata_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
`ifdef CORE_FETCH_PERF_EN
    output logic [31:0]     perf_fetch_stall_o,
    output logic [15:0]     perf_fetch_kill_o,
`endif
    output fetch_state_e    dbg_state_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e        state_q, state_d;
    logic                redir_pend_q;
    logic [XLEN-1:0]     redir_pc_q;
    logic [XLEN-1:0]     req_pc_q;
    logic                kill_q;
    logic [CW-1:0]       fifo_count;
    logic [CW:0]         credit_sum;
    logic                credit_ok;
    logic                rsp_in;
    logic                push;
    logic                pop;
    logic [XLEN+31:0]    head_data;

    assign rsp_in = (state_q == WAIT) && instr_rvalid_i;
    assign push   = rsp_in && !kill_q;
    assign pop    = instr_valid_o && instr_ready_i;

    // A redirect empties the buffer this cycle, so credit is judged on an empty FIFO.
    assign credit_sum = (branch_taken_i ? '0 : {1'b0, fifo_count})
                      + {{CW{1'b0}}, (state_q == WAIT)};
    assign credit_ok  = credit_sum < (CW+1)'(FIFO_DEPTH);

    always_comb begin
        state_d     = state_q;
        instr_req_o = 1'b0;
        pc_write_o  = 1'b0;
        unique case (state_q)
            IDLE: if (credit_ok) state_d = REQ;
            REQ: begin
                instr_req_o = 1'b1;
                if (instr_gnt_i) begin
                    pc_write_o = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: if (instr_rvalid_i) state_d = credit_ok ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign instr_addr_o   = instr_req_o ? (redir_pend_q ? redir_pc_q : pc_curr_i) : '0;
    assign branch_taken_o = pc_write_o && redir_pend_q;
    assign pc_branch_o    = redir_pc_q;
    assign dbg_state_o    = state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= '0;
            req_pc_q     <= '0;
            kill_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pc_write_o) begin
                req_pc_q     <= instr_addr_o;
                redir_pend_q <= 1'b0;
            end
            // A newer redirect overrides both an older one and the clear on grant.
            if (branch_taken_i) begin
                redir_pend_q <= 1'b1;
                redir_pc_q   <= pc_branch_i;
            end
            if (rsp_in) kill_q <= 1'b0;
            if (branch_taken_i && (((state_q == WAIT) && !instr_rvalid_i) || pc_write_o)) begin
                kill_q <= 1'b1;
            end
        end
    end

    core_fetch_fifo #(
        .WIDTH(XLEN + 32),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push       (push),
        .pop        (pop),
        .flush      (branch_taken_i),
        .wdata      ({req_pc_q, instr_rdata_i}),
        .count      (fifo_count),
        .head_valid (instr_valid_o),
        .head       (head_data)
    );

    assign instr_pc_o = head_data[XLEN+31:32];
    assign instr_o    = head_data[31:0];

`ifdef CORE_FETCH_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_fetch_stall_o <= '0;
            perf_fetch_kill_o  <= '0;
        end else begin
            if (instr_req_o && !instr_gnt_i && (perf_fetch_stall_o != '1)) begin
                perf_fetch_stall_o <= perf_fetch_stall_o + 32'd1;
            end
            if (rsp_in && kill_q && (perf_fetch_kill_o != '1)) begin
                perf_fetch_kill_o <= perf_fetch_kill_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_core_fetch_ctrl.sv
// Directed bench for core_fetch_ctrl with a small IF-stage PC model and an imem responder.
// Perf counter checks are active when CORE_FETCH_PERF_EN is defined.
module tb_core_fetch_ctrl;
    import core_fetch_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [31:0]  pc_reg;
    logic         pc_write_o, branch_taken_o, branch_taken_i;
    logic [31:0]  pc_branch_o, pc_branch_i;
    logic         instr_req_o, instr_gnt_i, instr_rvalid_i;
    logic [31:0]  instr_addr_o, instr_rdata_i;
    logic         instr_valid_o, instr_ready_i;
    logic [31:0]  instr_o, instr_pc_o;
    fetch_state_e dbg_state;
`ifdef CORE_FETCH_PERF_EN
    logic [31:0]  perf_stall;
    logic [15:0]  perf_kill;
`endif

    int total = 0;
    int bad   = 0;
    int cyc, lat, stall_left, resp_wait, pw_count, bt_count, first_pw;
    logic         resp_pend;
    logic [31:0]  resp_addr, bt_target;
    logic         s_req, s_gnt, s_pw, s_bt, s_rv;
    logic [31:0]  s_addr, s_pcb;
    logic [31:0]  exp_q[$];
    logic [31:0]  obs_pc[$];
    logic [31:0]  obs_instr[$];
    int           obs_cyc[$];

    always #5 clk_i = ~clk_i;

    core_fetch_ctrl #(.XLEN(32), .FIFO_DEPTH(2)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .pc_curr_i      (pc_reg),
        .pc_write_o     (pc_write_o),
        .branch_taken_o (branch_taken_o),
        .pc_branch_o    (pc_branch_o),
        .branch_taken_i (branch_taken_i),
        .pc_branch_i    (pc_branch_i),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_valid_o  (instr_valid_o),
        .instr_ready_i  (instr_ready_i),
        .instr_o        (instr_o),
        .instr_pc_o     (instr_pc_o),
`ifdef CORE_FETCH_PERF_EN
        .perf_fetch_stall_o (perf_stall),
        .perf_fetch_kill_o  (perf_kill),
`endif
        .dbg_state_o    (dbg_state)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
        total++;
        assert (obs_v === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
        end
    endtask

    // One clock: drive imem inputs at negedge, sample settled outputs, advance models after posedge.
    task automatic step();
        instr_gnt_i    = instr_req_o && (stall_left == 0);
        instr_rvalid_i = resp_pend && (resp_wait == 0);
        instr_rdata_i  = instr_rvalid_i ? mem_word(resp_addr) : 32'h0;
        #1;
        s_req = instr_req_o;  s_gnt = instr_gnt_i;  s_addr = instr_addr_o;
        s_pw  = pc_write_o;   s_bt  = branch_taken_o; s_pcb = pc_branch_o;
        s_rv  = instr_rvalid_i;
        if (instr_valid_o && instr_ready_i) begin
            obs_pc.push_back(instr_pc_o);
            obs_instr.push_back(instr_o);
            obs_cyc.push_back(cyc);
        end
        if (s_pw) begin
            pw_count++;
            if (first_pw < 0) first_pw = cyc;
        end
        if (s_bt) begin
            bt_count++;
            bt_target = s_pcb;
        end
        @(posedge clk_i);
        #1;
        cyc++;
        if (s_req && !s_gnt && stall_left > 0) stall_left--;
        if (s_rv) resp_pend = 1'b0;
        else if (resp_pend) resp_wait--;
        if (s_gnt) begin
            resp_pend = 1'b1;
            resp_addr = s_addr;
            resp_wait = lat - 1;
        end
        if (s_pw) pc_reg = s_bt ? s_pcb + 32'd4 : pc_reg + 32'd4;
        branch_taken_i = 1'b0;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic clear_models(input logic [31:0] pc0);
        pc_reg = pc0;
        resp_pend = 1'b0; resp_wait = 0; resp_addr = '0;
        stall_left = 0; lat = 1; cyc = 0;
        pw_count = 0; bt_count = 0; first_pw = -1; bt_target = '0;
        obs_pc.delete(); obs_instr.delete(); obs_cyc.delete(); exp_q.delete();
    endtask

    task automatic do_reset(input logic [31:0] pc0);
        rst_ni = 1'b0;
        branch_taken_i = 1'b0;
        instr_ready_i  = 1'b1;
        clear_models(pc0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic run_pops(input int n, input int budget);
        int k = 0;
        while (obs_pc.size() < n && k < budget) begin
            step();
            k++;
        end
    endtask

    task automatic wait_state(input fetch_state_e s, input int budget, input string tag);
        int k = 0;
        while (dbg_state != s && k < budget) begin
            step();
            k++;
        end
        chk(tag, dbg_state, s);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, ".count"}, obs_pc.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_pc.size(); i++) begin
            chk({tag, ".pc"}, obs_pc[i], exp_q[i]);
            chk({tag, ".instr"}, obs_instr[i], mem_word(exp_q[i]));
        end
        obs_pc.delete(); obs_instr.delete(); obs_cyc.delete(); exp_q.delete();
    endtask

    initial begin
        rst_ni = 1'b0;
        branch_taken_i = 1'b0; pc_branch_i = '0; instr_ready_i = 1'b1;
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
        clear_models(32'h1000_0000);
        repeat (2) @(negedge clk_i);

        // Reset values
        chk("rst.req",   instr_req_o, 0);
        chk("rst.addr",  instr_addr_o, 0);
        chk("rst.pw",    pc_write_o, 0);
        chk("rst.bt",    branch_taken_o, 0);
        chk("rst.pcb",   pc_branch_o, 0);
        chk("rst.valid", instr_valid_o, 0);
        chk("rst.instr", instr_o, 0);
        chk("rst.ipc",   instr_pc_o, 0);
        chk("rst.state", dbg_state, IDLE);

        // Straight line: one instruction every two cycles, gnt->valid two cycles
        do_reset(32'h1000_0000);
        run_pops(3, 40);
        if (obs_cyc.size() >= 3) begin
            chk("line.latency", obs_cyc[0] - first_pw, 2);
            chk("line.gap1", obs_cyc[1] - obs_cyc[0], 2);
            chk("line.gap2", obs_cyc[2] - obs_cyc[1], 2);
        end
        exp_q = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0008};
        check_stream("line");

        // ID stalled: buffer fills to two, fetching stops, then drains without loss
        do_reset(32'h1000_0000);
        instr_ready_i = 1'b0;
        repeat (8) step();
        chk("stall.pw_count", pw_count, 2);
        chk("stall.req", instr_req_o, 0);
        chk("stall.state", dbg_state, IDLE);
        chk("stall.valid", instr_valid_o, 1);
        chk("stall.head_pc", instr_pc_o, 32'h1000_0000);
        chk("stall.head_instr", instr_o, mem_word(32'h1000_0000));
        chk("stall.no_pops", obs_pc.size(), 0);
        instr_ready_i = 1'b1;
        run_pops(4, 40);
        exp_q = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0008, 32'h1000_000C};
        check_stream("stall");

        // Redirect while a response is in flight: that response is dropped
        do_reset(32'h1000_0000);
        lat = 3;
        wait_state(WAIT, 10, "kill.reach_wait");
        branch_taken_i = 1'b1; pc_branch_i = 32'h1000_0040;
        step();
        run_pops(2, 40);
        chk("kill.bt_count", bt_count, 1);
        chk("kill.bt_target", bt_target, 32'h1000_0040);
`ifdef CORE_FETCH_PERF_EN
        chk("kill.perf_kill", perf_kill, 1);
`endif
        exp_q = '{32'h1000_0040, 32'h1000_0044};
        check_stream("kill");

        // Redirect during a stalled request: address switches before the grant
        do_reset(32'h1000_0000);
        stall_left = 3;
        step();
        chk("req.addr_before", instr_addr_o, 32'h1000_0000);
        branch_taken_i = 1'b1; pc_branch_i = 32'h1000_0080;
        step();
        chk("req.addr_switched", instr_addr_o, 32'h1000_0080);
        chk("req.still_req", instr_req_o, 1);
        chk("req.no_pw_yet", pw_count, 0);
        run_pops(2, 40);
        chk("req.bt_count", bt_count, 1);
        chk("req.bt_target", bt_target, 32'h1000_0080);
`ifdef CORE_FETCH_PERF_EN
        chk("req.perf_stall", perf_stall, 3);
`endif
        exp_q = '{32'h1000_0080, 32'h1000_0084};
        check_stream("req");

        // Back-to-back redirects: only the newer target is fetched
        do_reset(32'h1000_0000);
        lat = 3;
        wait_state(WAIT, 10, "two.reach_wait");
        branch_taken_i = 1'b1; pc_branch_i = 32'h1000_0040;
        step();
        branch_taken_i = 1'b1; pc_branch_i = 32'h1000_0080;
        step();
        chk("two.fifo_empty", instr_valid_o, 0);
        run_pops(2, 40);
        chk("two.bt_count", bt_count, 1);
        chk("two.bt_target", bt_target, 32'h1000_0080);
        exp_q = '{32'h1000_0080, 32'h1000_0084};
        check_stream("two");

        // Redirect with a full buffer: contents flushed, new target fetched
        do_reset(32'h1000_0000);
        instr_ready_i = 1'b0;
        repeat (8) step();
        branch_taken_i = 1'b1; pc_branch_i = 32'h1000_0100;
        step();
        chk("flush.valid", instr_valid_o, 0);
        chk("flush.addr", instr_addr_o, 32'h1000_0100);
        instr_ready_i = 1'b1;
        run_pops(2, 40);
        exp_q = '{32'h1000_0100, 32'h1000_0104};
        check_stream("flush");

        // Asynchronous reset while waiting for a response
        do_reset(32'h1000_0000);
        lat = 3;
        wait_state(WAIT, 10, "arst.reach_wait");
        #2 rst_ni = 1'b0;
        #1;
        chk("arst.state", dbg_state, IDLE);
        chk("arst.req", instr_req_o, 0);
        chk("arst.pw", pc_write_o, 0);
        chk("arst.valid", instr_valid_o, 0);
        chk("arst.addr", instr_addr_o, 0);
        clear_models(32'h1000_0200);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
`ifdef CORE_FETCH_PERF_EN
        chk("arst.perf_stall", perf_stall, 0);
        chk("arst.perf_kill", perf_kill, 0);
`endif
        run_pops(1, 20);
        exp_q = '{32'h1000_0200};
        check_stream("arst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
